// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU sequencer. Drives an external 1-bit ALU
// slice LSB-first for WIDTH cycles and assembles the result and status flags.
module alu_serial_ctrl #(
    parameter int WIDTH = 24
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_binvert,
    output logic [1:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    localparam logic [1:0] SOP_AND = 2'b00;
    localparam logic [1:0] SOP_OR  = 2'b01;
    localparam logic [1:0] SOP_ADD = 2'b10;
    localparam logic [1:0] SOP_XOR = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Operation decoded once at accept so later op changes cannot leak in.
    typedef struct packed {
        logic [1:0] sop;    // slice operation select
        logic       sub;    // invert b and seed carry with 1
        logic       arith;  // ADD or SUB: carry/overflow are meaningful
    } opdec_t;

    state_t           state_q, state_d;
    opdec_t           dec_q, dec_in;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             op_valid;
    logic             last;

    assign op_valid = (op <= OP_XOR);
    assign last     = (cnt == CW'(WIDTH - 1));
    assign r_next   = {slice_result, r_sh[WIDTH-1:1]};

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = r_sh;

    // Decode the incoming op into slice controls; invalid ops decode to all-zero.
    always_comb begin
        dec_in = '0;
        case (op)
            OP_AND: dec_in.sop = SOP_AND;
            OP_OR:  dec_in.sop = SOP_OR;
            OP_ADD: begin dec_in.sop = SOP_ADD; dec_in.arith = 1'b1; end
            OP_SUB: begin dec_in.sop = SOP_ADD; dec_in.arith = 1'b1; dec_in.sub = 1'b1; end
            OP_XOR: dec_in.sop = SOP_XOR;
            default: dec_in = '0;
        endcase
    end

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: invalid ops skip RUN; DONE always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = op_valid ? RUN : DONE;
            RUN:  if (last)  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Slice drive: only active in RUN so the slice sees quiet zeros otherwise.
    always_comb begin
        slice_a       = 1'b0;
        slice_b       = 1'b0;
        slice_cin     = 1'b0;
        slice_binvert = 1'b0;
        slice_op      = 2'b00;
        if (state_q == RUN) begin
            slice_a       = a_sh[0];
            slice_b       = b_sh[0];
            slice_cin     = carry;
            slice_binvert = dec_q.sub;
            slice_op      = dec_q.sop;
        end
    end

    // Datapath: latch on accept, shift one bit per RUN edge, capture flags on the last bit.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            dec_q     <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh      <= a_in;
                        b_sh      <= b_in;
                        r_sh      <= '0;
                        cnt       <= '0;
                        carry     <= (op == OP_SUB);
                        dec_q     <= dec_in;
                        carry_out <= 1'b0;
                        overflow  <= 1'b0;
                        zero      <= 1'b0;
                        err       <= ~op_valid;
                    end
                end
                RUN: begin
                    r_sh  <= r_next;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= slice_cout;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        // carry still holds the carry into the MSB on this edge
                        carry_out <= dec_q.arith & slice_cout;
                        overflow  <= dec_q.arith & (carry ^ slice_cout);
                        zero      <= (r_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
